// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with a registered colour/sync output stage.
// Optional frame counter is enabled by defining VGA_FRAME_CNT_EN; otherwise frame reads 0.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       display_on,
  input  logic [5:0] color,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick,
  output logic [7:0] frame
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are inclusive ranges measured from the start of the line/frame.
  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] VActive = 10'(V_ACTIVE);
  localparam logic [9:0] HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HsFirst = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hcnt_q, vcnt_q;
  logic [5:0] rgb_q;
  logic       hsync_q, vsync_q, frame_tick_q;
  logic       hsync_window, vsync_window, line_end, frame_end;

  assign pix_x        = hcnt_q;
  assign pix_y        = vcnt_q;
  assign display_on   = (hcnt_q < HActive) && (vcnt_q < VActive);
  assign hsync_window = (hcnt_q >= HsFirst) && (hcnt_q <= HsLast);
  assign vsync_window = (vcnt_q >= VsFirst) && (vcnt_q <= VsLast);
  assign line_end     = (hcnt_q == HLast);
  assign frame_end    = line_end && (vcnt_q == VLast);

  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

  // Raster counters: hcnt wraps every line, vcnt advances on each line wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
    end else if (line_end) begin
      hcnt_q <= 10'd0;
      vcnt_q <= (vcnt_q == VLast) ? 10'd0 : vcnt_q + 10'd1;
    end else begin
      hcnt_q <= hcnt_q + 10'd1;
    end
  end

  // Output stage: colour and syncs sampled from the same counter state so they stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q        <= 6'd0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      rgb_q        <= display_on ? color : 6'd0;
      hsync_q      <= ~hsync_window;
      vsync_q      <= ~vsync_window;
      frame_tick_q <= frame_end;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_q;

  // Frame counter steps on the same edge that raises frame_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= 8'd0;
    end else if (frame_end) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign frame = frame_q;
`else
  assign frame = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line-level timing, shrunk instance for frame-level.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] color_a = 6'h3F;
  logic [5:0] color_b = 6'h2A;

  logic [9:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic       don_a, don_b, hs_a, hs_b, vs_a, vs_b, ft_a, ft_b;
  logic [5:0] rgb_a, rgb_b;
  logic [7:0] frame_a, frame_b;

  int n_checks = 0;
  int n_errors = 0;
  int n, m, pulses, doubles, fbad;
  logic ft_prev;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst), .pix_x(pix_x_a), .pix_y(pix_y_a), .display_on(don_a),
    .color(color_a), .rgb(rgb_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a),
    .frame(frame_a)
  );

  // Small raster: 16 clocks/line (hsync at 10..13), 10 lines/frame (vsync on lines 7..8).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_b (
    .clk(clk), .reset(rst), .pix_x(pix_x_b), .pix_y(pix_y_b), .display_on(don_b),
    .color(color_b), .rgb(rgb_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b),
    .frame(frame_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, both instances.
    tick(3);
    check("rst_pix_x", 32'(pix_x_a), 0);
    check("rst_pix_y", 32'(pix_y_a), 0);
    check("rst_display_on", 32'(don_a), 1);
    check("rst_rgb", 32'(rgb_a), 0);
    check("rst_hsync", 32'(hs_a), 1);
    check("rst_vsync", 32'(vs_a), 1);
    check("rst_frame_tick", 32'(ft_a), 0);
    check("rst_frame", 32'(frame_a), 0);
    check("rst_b_vsync", 32'(vs_b), 1);

    // First edge after release: hcnt=1, rgb shows pixel (0,0).
    rst = 1'b0;
    tick(1);
    check("first_pix_x", 32'(pix_x_a), 1);
    check("first_rgb", 32'(rgb_a), 32'h3F);

    // Blanking starts one cycle after pix_x reaches 640.
    tick(639);
    check("x640_pix_x", 32'(pix_x_a), 640);
    check("x640_display_on", 32'(don_a), 0);
    check("x640_rgb_prev", 32'(rgb_a), 32'h3F);
    tick(1);
    check("x641_rgb_blank", 32'(rgb_a), 0);

    // hsync falls one cycle after hcnt=656 and stays low 96 clocks.
    tick(15);
    check("x656_hsync", 32'(hs_a), 1);
    tick(1);
    check("x657_hsync", 32'(hs_a), 0);
    n = 0;
    while (hs_a === 1'b0 && n < 200) begin tick(1); n++; end
    check("hsync_low_line0", 32'(n), 96);
    check("hsync_rise_pix_x", 32'(pix_x_a), 753);
    m = 0;
    while (hs_a === 1'b1 && m < 1000) begin tick(1); m++; end
    check("line_period", 32'(n + m), 800);
    check("line1_pix_y", 32'(pix_y_a), 1);
    check("line1_pix_x", 32'(pix_x_a), 657);
    n = 0;
    while (hs_a === 1'b0 && n < 200) begin tick(1); n++; end
    check("hsync_low_line1", 32'(n), 96);

    // Fresh reset to align the small instance.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(159);
    check("b_last_pix_x", 32'(pix_x_b), 15);
    check("b_last_pix_y", 32'(pix_y_b), 9);
    check("b_last_tick", 32'(ft_b), 0);
    check("b_last_frame", 32'(frame_b), 0);
    tick(1);
    check("b_wrap_pix_x", 32'(pix_x_b), 0);
    check("b_wrap_pix_y", 32'(pix_y_b), 0);
    check("b_wrap_tick", 32'(ft_b), 1);
`ifdef VGA_FRAME_CNT_EN
    check("b_wrap_frame", 32'(frame_b), 1);
`else
    check("b_wrap_frame", 32'(frame_b), 0);
`endif

    // Three more frames: one-cycle frame_tick per frame; frame static when disabled.
    pulses = 0;
    doubles = 0;
    fbad = 0;
    ft_prev = ft_b;
    for (int i = 0; i < 480; i++) begin
      tick(1);
      if (ft_b === 1'b1) pulses++;
      if (ft_b === 1'b1 && ft_prev === 1'b1) doubles++;
`ifndef VGA_FRAME_CNT_EN
      if (frame_b !== 8'd0) fbad++;
`endif
      ft_prev = ft_b;
    end
    check("b_tick_pulses", 32'(pulses), 3);
    check("b_tick_wide", 32'(doubles), 0);
`ifdef VGA_FRAME_CNT_EN
    check("b_frame_after4", 32'(frame_b), 4);
    // 256 frames in total since reset: counter wraps back to 0.
    tick(252 * 160);
    check("b_frame_wrap", 32'(frame_b), 0);
    check("b_frame_wrap_tick", 32'(ft_b), 1);
`else
    check("b_frame_stays_zero", 32'(fbad), 0);
`endif

    // vsync: falls 113 clocks into the frame, low 32 clocks, period 160.
    n = 0;
    while (vs_b !== 1'b0 && n < 500) begin tick(1); n++; end
    check("b_vsync_fall", 32'(n), 113);
    n = 0;
    while (vs_b === 1'b0 && n < 500) begin tick(1); n++; end
    check("b_vsync_low", 32'(n), 32);
    m = 0;
    while (vs_b === 1'b1 && m < 500) begin tick(1); m++; end
    check("b_frame_period", 32'(n + m), 160);

    // Mid-frame reset while both syncs are low; takes effect without a clock edge.
    n = 0;
    while (!(pix_x_b == 10'd12 && pix_y_b == 10'd7) && n < 400) begin tick(1); n++; end
    check("b_pre_hsync", 32'(hs_b), 0);
    check("b_pre_vsync", 32'(vs_b), 0);
    #2 rst = 1'b1;
    #1;
    check("b_async_hsync", 32'(hs_b), 1);
    check("b_async_vsync", 32'(vs_b), 1);
    check("b_async_rgb", 32'(rgb_b), 0);
    check("b_async_pix_x", 32'(pix_x_b), 0);
    check("b_async_pix_y", 32'(pix_y_b), 0);
    check("a_async_pix_x", 32'(pix_x_a), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("b_recover_pix_x", 32'(pix_x_b), 1);
    check("b_recover_rgb", 32'(rgb_b), 32'h2A);
    check("a_recover_rgb", 32'(rgb_a), 32'h3F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing and drives the pixel coordinates that every flag pattern block consumes. It also registers the flag's 6-bit colour together with the sync signals so that RGB, hsync and vsync leave the chip aligned on the same clock edge. It sits between the pixel clock domain's top level and the flag multiplexer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in clocks
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal (25 MHz acceptable)
- reset  in  1  asynchronous, active-high
- pix_x  out  10  current horizontal counter, combinational from state
- pix_y  out  10  current vertical counter, combinational from state
- display_on  out  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE, combinational
- color  in  6  {R1,R0,G1,G0,B1,B0} from the flag block, computed from pix_x/pix_y in the same cycle
- rgb  out  6  registered colour, forced to 0 outside the active area
- hsync  out  1  registered, active low
- vsync  out  1  registered, active low
- frame_tick  out  1  registered one-cycle pulse on the first pixel of each frame
- frame  out  8  frame counter (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- hcnt counts from 0 to H_TOTAL-1 and then wraps to 0. On that wrap, vcnt increments; vcnt wraps from V_TOTAL-1 to 0.
- pix_x = hcnt; pix_y = vcnt.
- The sync window is active when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], which is [656,751]. vsync is active when vcnt is in [490,491].
- Output stage, on each clock edge:
  - rgb <= display_on ? color : 0
  - hsync <= ~hsync_window
  - vsync <= ~vsync_window
  - frame_tick <= (hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1)
- The block has no other state: no handshake, and it never stalls.
- Arithmetic: the counters are 10-bit unsigned. Compare against parameter sums only; the parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.

## Timing
- Reset values:
  - hcnt = 0, vcnt = 0, so pix_x = 0, pix_y = 0 and display_on = 1 during reset.
  - rgb = 0, hsync = 1, vsync = 1, frame_tick = 0, frame = 0.
- Latency: the registered outputs reflect the (hcnt, vcnt) state of the previous cycle, which is 1 clock of latency. rgb, hsync and vsync are mutually aligned.
- After reset deasserts:
  - The first active clock edge advances hcnt to 1.
  - rgb shows pixel (0,0) for the period following that edge.
- The line period is exactly 800 clocks. The frame period is exactly 420000 clocks.
- Horizontal wrap at end of line: when hcnt = 799, the next edge gives hcnt = 0 and vcnt+1. On the last line (vcnt = 524), it gives vcnt = 0.
- Simultaneous horizontal and vertical wrap: hcnt = 799 and vcnt = 524 → next state is (0,0), and frame_tick = 1 for exactly one cycle.
- Reset mid-frame takes effect immediately:
  - counters go to (0,0), sync outputs go inactive, rgb goes to 0.
  - No partial pulse is stretched.
- Blanking: rgb is 0 for every clock where the previous-cycle display_on was 0, regardless of the value on color.

## Configuration
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - frame is an 8-bit register that increments, wrapping 255→0, in the same cycle frame_tick is asserted.
  - Flag animation and cycling logic uses frame.
- When undefined:
  - frame is tied to 8'd0 and no register is synthesised.
  - frame_tick is still generated.

## Test plan
- Reset released with color held at 6'h3F: rgb is 6'h3F after the first edge. At pix_x = 640, pix_y = 0, the next-cycle rgb is 0.
- Hsync across 2 lines: hsync low for exactly 96 clocks per line, with the falling edge observed 1 cycle after hcnt = 656. Line period is 800 clocks.
- Vsync over 2 frames:
  - vsync low for exactly 1600 clocks (lines 490–491).
  - Frame period is 420000 clocks.
  - frame_tick pulses once per frame, 1 cycle wide.
- Wrap: at (799,524), the next cycle gives pix_x = 0 and pix_y = 0. With VGA_FRAME_CNT_EN, frame goes from 0 to 1, and after 256 frames it returns to 0.
- Reset asserted at hcnt = 700, vcnt = 490, while both syncs are active:
  - Both syncs return to 1 immediately, rgb = 0, and the counters are 0 without waiting for a clock edge.
  - Recovery timing then matches the first-reset case.
- Without VGA_FRAME_CNT_EN: frame stays 0 for 3 full frames while frame_tick still pulses 3 times.
